// File: rtl/mem_request_unit_if.sv
// mem_request_unit_if
// Data-memory request/response bus between mem_request_unit and the memory.
//
// Signals:
//   dmem_req    request valid, held for the whole access
//   dmem_we     1 = write, 0 = read
//   dmem_addr   byte address, stable while dmem_req=1
//   dmem_wdata  store data, stable while dmem_req=1
//   dmem_ack    one-cycle completion pulse from memory
//   dmem_rdata  load data, valid together with dmem_ack
//
// Modports:
//   master  request side (mem_request_unit)
//   slave   memory side
interface mem_request_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_request_unit.sv
// mem_request_unit
// Turns a load/store from the address-calculation stage into a data-memory
// request, stalls upstream while the access is outstanding, and hands the
// result to the memory-writeback register with a one-cycle done pulse.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   req_valid      upstream access valid
//   mem_read_in    access is a load
//   mem_write_in   access is a store (wins if both are set)
//   addr_in        byte address
//   write_data_in  store data
//   dmem           mem_request_unit_if.master data-memory bus
//   stall_out      hold upstream register (ISSUE/WAIT)
//   done_out       one-cycle completion pulse (RESP)
//   read_data_out  captured load data, 0 for stores and timeouts
//   error_out      timeout abort flag, pulsed with done_out
//
// Optional feature:
//   MEM_TIMEOUT_EN  when defined, an access that receives no ack within
//                   TIMEOUT_CYCLES ISSUE/WAIT cycles is aborted with error_out.
module mem_request_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                mem_read_in,
    input  logic                mem_write_in,
    input  logic [31:0]         addr_in,
    input  logic [31:0]         write_data_in,
    mem_request_unit_if.master  dmem,
    output logic                stall_out,
    output logic                done_out,
    output logic [31:0]         read_data_out,
    output logic                error_out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        busy;
    logic        accept;
    logic        timeout_hit;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] read_data_q;
    logic        err_q;

    // A new access can only be taken when nothing is outstanding; a valid
    // with neither read nor write set is not an access at all.
    assign busy   = (state == ISSUE) || (state == WAIT);
    assign accept = req_valid && (mem_read_in || mem_write_in) &&
                    ((state == IDLE) || (state == RESP));

`ifdef MEM_TIMEOUT_EN
    localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [CountWidth-1:0] wait_count;

    // Counts the ISSUE/WAIT cycles of the current access; restarted on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count <= '0;
        end else if (accept) begin
            wait_count <= '0;
        end else if (busy) begin
            wait_count <= wait_count + 1'b1;
        end
    end

    // The last permitted request cycle ends the access unless the memory
    // acknowledges in that same cycle; an ack always wins.
    assign timeout_hit = busy && !dmem.dmem_ack &&
                         (wait_count == CountWidth'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: acks are only meaningful while a request is out.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                if (dmem.dmem_ack || timeout_hit) begin
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                end
            end
            RESP: begin
                if (accept) begin
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request registers: loaded only on accept so the bus stays stable for
    // the whole access. Both read and write set is treated as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr_in;
            wdata_q <= write_data_in;
            we_q    <= mem_write_in;
        end
    end

    // Response capture: loads keep the returned data, stores and aborted
    // accesses leave zero. The value holds until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else if (busy && dmem.dmem_ack) begin
            read_data_q <= we_q ? 32'h0 : dmem.dmem_rdata;
            err_q       <= 1'b0;
        end else if (timeout_hit) begin
            read_data_q <= 32'h0;
            err_q       <= 1'b1;
        end
    end

    assign dmem.dmem_req   = busy;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

    assign stall_out     = busy;
    assign done_out      = (state == RESP);
    assign read_data_out = read_data_q;

`ifdef MEM_TIMEOUT_EN
    assign error_out = (state == RESP) && err_q;
`else
    assign error_out = 1'b0;
`endif

endmodule

// File: doc/mem_request_unit.md
MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max ISSUE+WAIT cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  upstream address-calculation stage presents a valid access.
REQ-005 mem_read_in  input  1  access is a load.
REQ-006 mem_write_in  input  1  access is a store.
REQ-007 addr_in  input  32  byte address.
REQ-008 write_data_in  input  32  store data.
REQ-009 dmem_req  output  1  request to data memory.
REQ-010 dmem_we  output  1  1 = write, 0 = read.
REQ-011 dmem_addr  output  32  registered request address.
REQ-012 dmem_wdata  output  32  registered store data.
REQ-013 dmem_ack  input  1  memory completion, one-cycle pulse.
REQ-014 dmem_rdata  input  32  load data, valid when dmem_ack=1.
REQ-015 stall_out  output  1  hold upstream register.
REQ-016 done_out  output  1  one-cycle completion pulse to downstream memory-writeback register.
REQ-017 read_data_out  output  32  captured load data.
REQ-018 error_out  output  1  timeout abort flag, pulsed with done_out.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 Accept SHALL occur in IDLE or RESP when req_valid=1 and (mem_read_in or mem_write_in): latch addr, wdata, we=mem_write_in; next state ISSUE.
REQ-021 req_valid with both mem_read_in and mem_write_in low SHALL be ignored; both high SHALL be treated as a write.
REQ-022 dmem_req SHALL be 1 exactly in ISSUE and WAIT; dmem_addr/dmem_we/dmem_wdata SHALL stay stable while dmem_req=1.
REQ-023 ISSUE: dmem_ack=1 -> RESP; else -> WAIT. WAIT: dmem_ack=1 -> RESP; else remain.
REQ-024 On the ack edge, read_data_out SHALL load dmem_rdata for reads and 32'h0 for writes.
REQ-025 stall_out SHALL be combinational, 1 exactly in ISSUE and WAIT.
REQ-026 done_out SHALL be 1 exactly in RESP; minimum latency accept -> done_out = 2 cycles (ack in ISSUE).
REQ-027 RESP without new accept -> IDLE; with accept -> ISSUE, back-to-back, no bubble.
REQ-028 dmem_ack in IDLE or RESP SHALL be ignored, no state or data change.
REQ-029 read_data_out SHALL hold its value until the next ack or reset.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and all outputs to 0 (dmem_* , stall_out, done_out, read_data_out, error_out), aborting any in-flight access; a subsequent ack SHALL be ignored.
REQ-031 reset SHALL take priority over accept and ack in the same cycle.

Configuration
REQ-032 Macro MEM_TIMEOUT_EN defined: a counter SHALL clear on accept, increment each ISSUE/WAIT cycle; on reaching TIMEOUT_CYCLES without ack -> RESP with error_out=1, read_data_out=32'h0, dmem_req dropped.
REQ-033 MEM_TIMEOUT_EN undefined: no counter, WAIT SHALL persist indefinitely, error_out tied 0.

Verification
REQ-034 Read, addr 0x100, ack in ISSUE with rdata 0xCAFE0001 -> dmem_req 1 cycle, done_out at cycle 2, read_data_out=0xCAFE0001, stall_out 1 cycle.
REQ-035 Write, addr 0x200, wdata 0x12345678, ack after 3 WAIT cycles -> dmem_we=1, dmem_addr/wdata stable 4 cycles, stall_out 4 cycles, read_data_out=0.
REQ-036 Back-to-back reads 0x10 then 0x14 with accept in RESP -> second ISSUE immediately after first done_out, no IDLE cycle.
REQ-037 Reset asserted in WAIT, ack next cycle -> all outputs 0, state IDLE, ack ignored, done_out stays 0.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req 4 cycles, then done_out=1 and error_out=1 together, read_data_out=0.
REQ-039 req_valid=1 with mem_read_in=mem_write_in=0, and stray ack in IDLE -> no dmem_req, no state change.
